// File: rtl/xaxi4_pkg.sv
// Shared AXI4 encodings, checker FSM state type and beat-pattern helpers
// for the xaxi4 burst checker.
package xaxi4_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_AR,
    S_R,
    S_NEXT,
    S_DONE
  } state_e;

  function automatic logic [2:0] size_of(input int unsigned width);
    case (width)
      8:       return 3'd0;
      16:      return 3'd1;
      32:      return 3'd2;
      64:      return 3'd3;
      128:     return 3'd4;
      256:     return 3'd5;
      512:     return 3'd6;
      1024:    return 3'd7;
      default: return 3'd2;
    endcase
  endfunction

  // Lane k of a beat at byte address A carries (A + 4k) ^ seed.
  function automatic logic [31:0] pattern_word(input logic [31:0]   addr,
                                               input logic [31:0]   seed,
                                               input int unsigned   lane);
    return (addr + 32'(lane * 4)) ^ seed;
  endfunction

endpackage

// File: rtl/xaxi4_burst_checker.sv
// AXI4 master traffic engine: writes INCR bursts with a seeded address pattern,
// reads each one back and counts protocol/data errors.
module xaxi4_burst_checker
  import xaxi4_pkg::*;
#(
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int TXN_ID         = 0
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          i_start,
  input  logic [AXI_ADDR_WIDTH-1:0]     i_base_addr,
  input  logic [7:0]                    i_len,
  input  logic [15:0]                   i_num_bursts,
  input  logic [31:0]                   i_seed,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [15:0]                   o_err_cnt,
  output logic [AXI_ADDR_WIDTH-1:0]     o_first_err_addr,
  output logic                          o_awvalid,
  input  logic                          i_awready,
  output logic [AXI_ID_WIDTH-1:0]       o_awid,
  output logic [AXI_ADDR_WIDTH-1:0]     o_awaddr,
  output logic [7:0]                    o_awlen,
  output logic [2:0]                    o_awsize,
  output logic [1:0]                    o_awburst,
  output logic                          o_awlock,
  output logic [3:0]                    o_awcache,
  output logic [2:0]                    o_awprot,
  output logic [3:0]                    o_awqos,
  output logic [3:0]                    o_awregion,
  output logic                          o_wvalid,
  input  logic                          i_wready,
  output logic [AXI_ID_WIDTH-1:0]       o_wid,
  output logic [AXI_DATA_WIDTH-1:0]     o_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   o_wstrb,
  output logic                          o_wlast,
  input  logic                          i_bvalid,
  output logic                          o_bready,
  input  logic [AXI_ID_WIDTH-1:0]       i_bid,
  input  logic [1:0]                    i_bresp,
  output logic                          o_arvalid,
  input  logic                          i_arready,
  output logic [AXI_ID_WIDTH-1:0]       o_arid,
  output logic [AXI_ADDR_WIDTH-1:0]     o_araddr,
  output logic [7:0]                    o_arlen,
  output logic [2:0]                    o_arsize,
  output logic [1:0]                    o_arburst,
  output logic                          o_arlock,
  output logic [3:0]                    o_arcache,
  output logic [2:0]                    o_arprot,
  output logic [3:0]                    o_arqos,
  output logic [3:0]                    o_arregion,
  input  logic                          i_rvalid,
  output logic                          o_rready,
  input  logic [AXI_ID_WIDTH-1:0]       i_rid,
  input  logic [1:0]                    i_rresp,
  input  logic [AXI_DATA_WIDTH-1:0]     i_rdata,
  input  logic                          i_rlast
);

  localparam int unsigned                BYTES    = AXI_DATA_WIDTH / 8;
  localparam int unsigned                LANES    = AXI_DATA_WIDTH / 32;
  localparam logic [2:0]                 SIZE     = size_of(AXI_DATA_WIDTH);
  localparam logic [AXI_ID_WIDTH-1:0]    ID       = AXI_ID_WIDTH'(TXN_ID);
  localparam logic [AXI_ADDR_WIDTH-1:0]  BEAT_INC = AXI_ADDR_WIDTH'(BYTES);

  state_e                       state_q;
  logic                         busy_q, done_q;
  logic                         awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q;
  logic [7:0]                   len_q, beat_q;
  logic [15:0]                  num_q, idx_q;
  logic [31:0]                  seed_q;
  logic [AXI_ADDR_WIDTH-1:0]    burst_addr_q, beat_addr_q, stride_q;
  logic [15:0]                  err_cnt_q, err_cnt_d;
  logic [AXI_ADDR_WIDTH-1:0]    first_err_q, first_err_d;

  logic [AXI_ADDR_WIDTH-1:0]    stride_d;
  logic [AXI_DATA_WIDTH-1:0]    exp_data;
  logic                         b_err, r_err, err_ev;
  logic [AXI_ADDR_WIDTH-1:0]    err_addr;

  assign stride_d = AXI_ADDR_WIDTH'({1'b0, i_len} + 9'd1) << SIZE;

  // The pattern generator is shared: beat_addr_q tracks the W beat while
  // writing and the R beat while reading.
  always_comb begin
    exp_data = '0;
    for (int unsigned k = 0; k < LANES; k++)
      exp_data[32*k +: 32] = pattern_word(32'(beat_addr_q), seed_q, k);
  end

  assign b_err = (i_bresp != OKAY) || (i_bid != ID);
  assign r_err = (i_rdata != exp_data) || (i_rresp != OKAY) || (i_rid != ID) ||
                 (i_rlast != (beat_q == len_q));

  assign err_ev   = (state_q == S_B && bready_q && i_bvalid && b_err) ||
                    (state_q == S_R && rready_q && i_rvalid && r_err);
  assign err_addr = (state_q == S_B) ? burst_addr_q : beat_addr_q;

  assign err_cnt_d   = (err_ev && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
  assign first_err_d = (err_ev && err_cnt_q == 16'd0) ? err_addr : first_err_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      wlast_q      <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      len_q        <= '0;
      beat_q       <= '0;
      num_q        <= '0;
      idx_q        <= '0;
      seed_q       <= '0;
      burst_addr_q <= '0;
      beat_addr_q  <= '0;
      stride_q     <= '0;
      err_cnt_q    <= '0;
      first_err_q  <= '0;
    end else begin
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            len_q        <= i_len;
            num_q        <= i_num_bursts;
            seed_q       <= i_seed;
            burst_addr_q <= i_base_addr;
            stride_q     <= stride_d;
            idx_q        <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b1;
            err_cnt_q    <= '0;
            first_err_q  <= '0;
            if (i_num_bursts == 16'd0) begin
              state_q <= S_DONE;
            end else begin
              awvalid_q <= 1'b1;
              state_q   <= S_AW;
            end
          end
        end
        S_AW: begin
          if (i_awready) begin
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b1;
            beat_q      <= '0;
            beat_addr_q <= burst_addr_q;
            wlast_q     <= (len_q == 8'd0);
            state_q     <= S_W;
          end
        end
        S_W: begin
          if (i_wready) begin
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= S_B;
            end else begin
              beat_q      <= beat_q + 8'd1;
              beat_addr_q <= beat_addr_q + BEAT_INC;
              wlast_q     <= (beat_q + 8'd1 == len_q);
            end
          end
        end
        S_B: begin
          if (i_bvalid) begin
            bready_q  <= 1'b0;
            arvalid_q <= 1'b1;
            state_q   <= S_AR;
          end
        end
        S_AR: begin
          if (i_arready) begin
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b1;
            beat_q      <= '0;
            beat_addr_q <= burst_addr_q;
            state_q     <= S_R;
          end
        end
        S_R: begin
          // Exit is driven by the local beat count, not by i_rlast.
          if (i_rvalid) begin
            if (beat_q == len_q) begin
              rready_q <= 1'b0;
              state_q  <= S_NEXT;
            end else begin
              beat_q      <= beat_q + 8'd1;
              beat_addr_q <= beat_addr_q + BEAT_INC;
            end
          end
        end
        S_NEXT: begin
          idx_q        <= idx_q + 16'd1;
          burst_addr_q <= burst_addr_q + stride_q;
          if (idx_q + 16'd1 == num_q) begin
            state_q <= S_DONE;
          end else begin
            awvalid_q <= 1'b1;
            state_q   <= S_AW;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_busy           = busy_q;
  assign o_done           = done_q;
  assign o_err_cnt        = err_cnt_q;
  assign o_first_err_addr = first_err_q;

  // Size/burst are held at zero outside a run so reset leaves every output low.
  assign o_awvalid  = awvalid_q;
  assign o_awid     = ID;
  assign o_awaddr   = burst_addr_q;
  assign o_awlen    = len_q;
  assign o_awsize   = busy_q ? SIZE : 3'd0;
  assign o_awburst  = busy_q ? INCR : 2'b00;
  assign o_awlock   = 1'b0;
  assign o_awcache  = 4'd0;
  assign o_awprot   = 3'd0;
  assign o_awqos    = 4'd0;
  assign o_awregion = 4'd0;

  assign o_wvalid = wvalid_q;
  assign o_wid    = ID;
  assign o_wdata  = wvalid_q ? exp_data : '0;
  assign o_wstrb  = wvalid_q ? '1 : '0;
  assign o_wlast  = wlast_q;

  assign o_bready = bready_q;

  assign o_arvalid  = arvalid_q;
  assign o_arid     = ID;
  assign o_araddr   = burst_addr_q;
  assign o_arlen    = len_q;
  assign o_arsize   = busy_q ? SIZE : 3'd0;
  assign o_arburst  = busy_q ? INCR : 2'b00;
  assign o_arlock   = 1'b0;
  assign o_arcache  = 4'd0;
  assign o_arprot   = 3'd0;
  assign o_arqos    = 4'd0;
  assign o_arregion = 4'd0;

  assign o_rready = rready_q;

endmodule

// File: doc/xaxi4_burst_checker.md
Name: xaxi4_burst_checker

Overview:
- AXI4 master traffic engine that sits directly upstream of xaxi4_slave_emb_wrapper and drives all of its AW/W/B/AR/R channels.
- Writes a programmable number of INCR bursts with a deterministic data pattern, reads each burst back, and compares the read data.
- Reports busy, done and error status for emulation memory bring-up and for latency-control regression.

Parameters:
AXI_ID_WIDTH, 4, ID width; must match the slave.
AXI_DATA_WIDTH, 32, data bus width (32/64/128/256/512).
AXI_ADDR_WIDTH, 32, address width.
TXN_ID, 0, constant ID driven on o_awid, o_wid and o_arid.

Ports:
aclk  in  1  clock
aresetn  in  1  async active-low reset
i_start  in  1  one-cycle start pulse; ignored while o_busy=1
i_base_addr  in  AXI_ADDR_WIDTH  first burst address; aligned to AXI_DATA_WIDTH/8
i_len  in  8  beats per burst minus 1 (AxLEN)
i_num_bursts  in  16  number of write+read burst pairs
i_seed  in  32  pattern seed
o_busy  out  1  run in progress
o_done  out  1  sticky run-complete flag; cleared by i_start
o_err_cnt  out  16  error count, saturating
o_first_err_addr  out  AXI_ADDR_WIDTH  beat address of the first error
o_awvalid/i_awready, o_awid, o_awaddr, o_awlen[7:0], o_awsize[2:0], o_awburst[1:0]  AW channel
o_awlock=0, o_awcache=0, o_awprot=0, o_awqos=0, o_awregion=0  constant AW sidebands
o_wvalid/i_wready, o_wid, o_wdata, o_wstrb, o_wlast  W channel
i_bvalid/o_bready, i_bid, i_bresp[1:0]  B channel
o_arvalid/i_arready, o_arid, o_araddr, o_arlen, o_arsize, o_arburst, plus AR sidebands=0  AR channel
i_rvalid/o_rready, i_rid, i_rresp[1:0], i_rdata, i_rlast  R channel

Behaviour:
- Clock and reset: one clock, aclk; reset aresetn is asynchronous and active-low.
- Reset values: every output is 0, the FSM is in IDLE, o_err_cnt=0 and o_first_err_addr=0. Reset mid-burst aborts immediately; there is no drain.
- Fixed fields: AxSIZE=log2(AXI_DATA_WIDTH/8); AxBURST=INCR (2'b01); o_wstrb all ones. Only one transaction is outstanding at a time.
- Burst address: addr(n) = i_base_addr + n*(i_len+1)*(AXI_DATA_WIDTH/8), computed mod 2^AXI_ADDR_WIDTH.
- Pattern: for a beat at byte address A, each 32-bit lane k carries (A + 4k) ^ i_seed.
- Config capture: all config inputs are latched on the accepted i_start; later changes have no effect until the next run.
- FSM states: IDLE, AW, W, B, AR, R, NEXT, DONE.
- IDLE: on i_start, clear o_done, o_err_cnt and o_first_err_addr, and set o_busy. Go to DONE if i_num_bursts==0, otherwise to AW.
- AW: o_awvalid=1 until i_awready, then go to W. Address and control stay stable while valid is high.
- W: o_wvalid=1; the beat advances on i_wready. o_wlast=1 on beat i_len. After the last handshake go to B.
- B: o_bready=1. On i_bvalid, count one error if i_bresp!=0 or i_bid!=TXN_ID, then go to AR.
- AR: same rules as AW, then go to R.
- R: o_rready=1. On each i_rvalid beat, count one error per beat if any of these hold:
  - data mismatch;
  - i_rresp!=0;
  - i_rid!=TXN_ID;
  - i_rlast differs from (beat==i_len).
- R exit: leave R on the handshake of the i_len-th beat, regardless of i_rlast. Go to NEXT.
- NEXT: increment the burst index. Go to DONE if it equals i_num_bursts, otherwise to AW. NEXT lasts one cycle.
- DONE: clear o_busy and set o_done in the same cycle, then go to IDLE. i_start in this cycle is ignored.
- Error count: saturates at 16'hFFFF. o_first_err_addr is written only on the 0->1 transition of the count. A B-channel error records the burst base address.
- Latency: i_start to o_awvalid is 1 cycle.
- Address wrap and 4KB: wrap across 2^AXI_ADDR_WIDTH is silent. Crossing a 4KB boundary is the caller's responsibility; no check is made.

Decomposition:
- Package xaxi4_pkg holds:
  - resp constants OKAY/EXOKAY/SLVERR/DECERR and burst constants FIXED/INCR/WRAP;
  - the FSM state enum typedef;
  - function size_of(width) returning AxSIZE;
  - function pattern_word(addr, seed, lane).
- No sub-module; a single always_ff FSM plus a datapath.

Test Plan:
- Base 0x0, len 0, 1 burst, seed 0, zero delays -> one AW/W/B/AR/R each; rdata 0x0; o_done=1; err_cnt 0.
- Base 0x100, len 15, 4 bursts, seed 0xA5A5A5A5, delays i_awready_delay=5, i_wready_delay=3, i_arready_delay=7, i_ar_rvalid_delay=10 -> 4 write and 4 read bursts at 0x100/0x140/0x180/0x1C0; err_cnt 0.
- Slave model forces i_bresp=SLVERR on burst 2 (base 0x40, len 3) -> err_cnt 1; first_err_addr 0x40+2*16=0x60.
- Corrupt rdata on beat 5 of burst 0 (base 0x200, len 7, 32-bit) -> err_cnt 1; first_err_addr 0x214.
- Hold i_awready low and pulse i_start again mid-run -> second start ignored; o_awvalid and o_awaddr stay stable; deassert aresetn mid-W -> all outputs 0 on the same edge.
- i_num_bursts=0 -> o_busy high one cycle, o_done=1, no AXI valid ever asserted.
